// File: rtl/adder24_share_ctrl.sv
// Round-robin time-sharing controller for one external combinational 24-bit adder.
// Optional signed-overflow flag on rsp_ovf is enabled by defining ADD24_SHARE_OVF_EN.
module adder24_share_ctrl #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 24,
  parameter int SETTLE_CYCLES = 2,
  parameter int ID_W          = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_cin,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_cin,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_cout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_cout,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_ovf
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_INIT = ID_W'(NUM_REQ - 1);

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   add_a_q, add_a_d, add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [ID_W-1:0]    grant_s;
  logic               any_s;
  logic [NUM_REQ-1:0] ready_s;
  logic [WIDTH-1:0]   sel_a_s, sel_b_s;
  logic               sel_cin_s;

  // Search from last+1 upward with wrap; iterating downward lets the nearest hit win.
  always_comb begin
    grant_s = '0;
    any_s   = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last_q) + k) % NUM_REQ]) begin
        grant_s = ID_W'((int'(last_q) + k) % NUM_REQ);
        any_s   = 1'b1;
      end else begin
        any_s   = any_s;
      end
    end
  end

  // One-hot accept strobe, only while idle and someone is asking.
  always_comb begin
    ready_s = '0;
    if ((state_q == ST_IDLE) && any_s) begin
      ready_s[grant_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign sel_a_s   = req_a[int'(grant_s)*WIDTH +: WIDTH];
  assign sel_b_s   = req_b[int'(grant_s)*WIDTH +: WIDTH];
  assign sel_cin_s = req_cin[grant_s];

  // Next-state and datapath update for the IDLE/SETTLE/RESP sequence.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          add_a_d   = sel_a_s;
          add_b_d   = sel_b_s;
          add_cin_d = sel_cin_s;
          rsp_id_d  = grant_s;
          last_d    = grant_s;
          cnt_d     = CNT_INIT;
          state_d   = ST_SETTLE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d       = cnt_q - 1'b1;
        end else begin
          rsp_sum_d   = add_s;
          rsp_cout_d  = add_cout;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= LAST_INIT;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

`ifdef ADD24_SHARE_OVF_EN
  logic ovf_q;

  // Signed overflow: like-signed operands producing a sum of the other sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if ((state_q == ST_SETTLE) && (cnt_q == '0)) begin
      ovf_q <= (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
               (add_s[WIDTH-1] != add_a_q[WIDTH-1]);
    end else begin
      ovf_q <= ovf_q;
    end
  end

  assign rsp_ovf = ovf_q;
`else
  assign rsp_ovf = 1'b0;
`endif

  assign req_ready = ready_s;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = rsp_id_q;

endmodule

// File: doc/adder24_share_ctrl.md
Name: adder24_share_ctrl

Overview:
- Time-shares one combinational 24-bit ripple-carry adder among NUM_REQ requesters.
- Round-robin arbitration selects one requester, registers its operands onto the adder inputs, and waits SETTLE_CYCLES cycles for the ripple carry to settle.
- Captures sum and carry-out, then returns them with the requester ID over a valid/ready response port.
- Sits between the multiplier/accumulation logic and the instantiated 24-bit adder.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 24, operand width; must match the adder
- SETTLE_CYCLES, 2, cycles operands are held before result capture (>=1)
- ID_W, 2, requester ID width; must equal max(1, clog2(NUM_REQ))

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept strobe
- req_a  in  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing as req_a
- req_cin  in  NUM_REQ  carry-in per requester
- add_a  out  WIDTH  registered operand A to the adder
- add_b  out  WIDTH  registered operand B to the adder
- add_cin  out  1  registered carry-in to the adder
- add_s  in  WIDTH  adder sum
- add_cout  in  1  adder carry-out
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_sum  out  WIDTH  captured sum
- rsp_cout  out  1  captured carry-out
- rsp_id  out  ID_W  index of the requester that owns the result
- rsp_ovf  out  1  signed overflow flag (see Optional Feature)

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low, rst_n.
  - On reset: state=IDLE; add_a, add_b, add_cin, rsp_* cleared to 0; req_ready=0; settle counter=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 wins first.
- FSM has three states: IDLE, SETTLE, RESP.
- IDLE:
  - Grant g is the first i with req_valid[i], searching from last+1 upward and wrapping modulo NUM_REQ.
  - req_ready[g] is driven combinationally high only in IDLE, only for g, and only while any req_valid is high.
  - At the accept edge: add_a/add_b/add_cin <= requester g's fields; rsp_id <= g; last <= g; counter <= SETTLE_CYCLES-1; next state SETTLE.
  - No valid request: stay in IDLE.
- SETTLE:
  - All req_ready are 0; add_* are held stable.
  - counter!=0: decrement.
  - counter==0: rsp_sum <= add_s; rsp_cout <= add_cout; rsp_valid <= 1; next state RESP.
- Latency: rsp_valid rises exactly SETTLE_CYCLES cycles after the accept edge.
- RESP:
  - rsp_* are held stable while rsp_valid && !rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid <= 0; next state IDLE.
  - No grant is issued in the same cycle as the response handshake.
- Throughput: at most one operation per SETTLE_CYCLES+2 cycles.
- add_a/add_b/add_cin keep their last value after completion; they are not cleared.
- Requester rule: once req_valid is raised, it and the operands stay stable until req_ready. Operand changes while not granted are ignored.
- Simultaneous valids: exactly one grant per IDLE cycle. Continuously requesting requesters are served in strict rotation; no starvation.
- Reset mid-operation (SETTLE or RESP): the in-flight result is discarded and rsp_valid drops immediately (asynchronously). The requester must re-present its request after reset.
- Arithmetic: rsp_sum/rsp_cout are whatever the adder produces, captured unmodified, WIDTH+1 bits total.

Optional Feature:
- Macro: ADD24_SHARE_OVF_EN.
- Defined:
  - rsp_ovf is registered at capture as (add_a[WIDTH-1]==add_b[WIDTH-1]) && (add_s[WIDTH-1]!=add_a[WIDTH-1]).
  - rsp_ovf is held and cleared like the other rsp_* outputs.
- Undefined: rsp_ovf is tied to 0 and no overflow logic is generated.

Test Plan:
- Reset: assert rst_n=0 mid-clock -> all outputs 0 immediately; after release with no req_valid, stays IDLE, req_ready=0.
- Single op: req0 a=0x000001, b=0xFFFFFF, cin=0, SETTLE_CYCLES=2 -> rsp_valid exactly 2 cycles after accept; sum=0x000000, cout=1, id=0.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1, each requester's operands distinct -> rsp_id sequence 0,1,2,3,0; each sum correct.
- Backpressure: rsp_ready=0 for 5 cycles with req1 pending -> rsp_* stable, req_ready=0; req1 granted only in the cycle after the rsp handshake.
- Overflow: a=0x7FFFFF, b=0x000001, cin=0 -> sum=0x800000, cout=0; rsp_ovf=1 with ADD24_SHARE_OVF_EN, 0 without.
- Reset during SETTLE: req2 granted, rst_n pulsed low -> rsp_valid never rises for that op; after release with req0 and req2 valid, req0 is granted first.
